// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, picks the next PC from PcSource,
// keeps a circular return-address stack and registers the IF/ID stage.
module fetch_pc_unit #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP       = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         PcSource,
    input  logic               SIG_Kill,
    input  logic               SIG_Stall,
    input  logic               SIG_Call,
    input  logic               SIG_CallRs1,
    input  logic [ADDR_W-1:0]  JumpTarget,
    input  logic [ADDR_W-1:0]  BranchTarget,
    input  logic [ADDR_W-1:0]  Rs1Target,
    output logic [ADDR_W-1:0]  ImemAddr,
    input  logic [INSTR_W-1:0] ImemData,
    output logic [INSTR_W-1:0] IfIdInstr,
    output logic [ADDR_W-1:0]  IfIdPc,
    output logic [ADDR_W-1:0]  IfIdPcPlus4,
    output logic               IfIdValid,
    output logic               RasEmpty,
    output logic               RasOverflow,
    output logic               RasUnderflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d, pc_plus4;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [ADDR_W-1:0]  ifid_pcp4_q, ifid_pcp4_d;
    logic               ifid_valid_q, ifid_valid_d;

    logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]   ptr_q, ptr_d, wr_idx;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic               push, pop, wr_en;
    logic [ADDR_W-1:0]  ras_top;

    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign ras_top  = ras_q[ptr_q];
    assign push     = (SIG_Call | SIG_CallRs1) & ifid_valid_q & ~SIG_Stall;
    assign pop      = (PcSource == 3'b100) & ifid_valid_q & ~SIG_Stall;

    always_comb begin
        pc_d = pc_q;
        if (!SIG_Stall) begin
            unique case (PcSource)
                3'b001:  pc_d = JumpTarget;
                3'b010:  pc_d = BranchTarget;
                3'b011:  pc_d = Rs1Target;
                3'b100:  pc_d = ras_top;
                default: pc_d = pc_plus4;
            endcase
        end
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pcp4_d  = ifid_pcp4_q;
        ifid_valid_d = ifid_valid_q;
        if (!SIG_Stall) begin
            ifid_pc_d    = pc_q;
            ifid_pcp4_d  = pc_plus4;
            ifid_valid_d = ~SIG_Kill;
            ifid_instr_d = SIG_Kill ? NOP : ImemData;
        end
    end

    // A simultaneous push and pop swaps the top entry in place; an empty pop
    // still walks the pointer back so the stale-entry behaviour is repeatable.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push && pop) begin
            wr_en = 1'b1;
            if (cnt_q == '0) unf_d = 1'b1;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q + PTR_W'(1);
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q == CNT_FULL) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + CNT_W'(1);
        end else if (pop) begin
            ptr_d = ptr_q - PTR_W'(1);
            if (cnt_q == '0) unf_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_pcp4_q  <= '0;
            ifid_valid_q <= 1'b0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pcp4_q  <= ifid_pcp4_d;
            ifid_valid_q <= ifid_valid_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    // Stack storage is not reset; an underflowing pop deliberately exposes stale data.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) ras_q[wr_idx] <= ifid_pcp4_q;
    end

    assign ImemAddr     = pc_q;
    assign IfIdInstr    = ifid_instr_q;
    assign IfIdPc       = ifid_pc_q;
    assign IfIdPcPlus4  = ifid_pcp4_q;
    assign IfIdValid    = ifid_valid_q;
    assign RasEmpty     = (cnt_q == '0);
    assign RasOverflow  = ovf_q;
    assign RasUnderflow = unf_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: fetch sequencing, redirects, RAS push/pop,
// overflow/underflow, stall hold and reset during stall.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PcSource;
    logic        SIG_Kill, SIG_Stall, SIG_Call, SIG_CallRs1;
    logic [31:0] JumpTarget, BranchTarget, Rs1Target;
    logic [31:0] ImemAddr, ImemData, IfIdInstr, IfIdPc, IfIdPcPlus4;
    logic        IfIdValid, RasEmpty, RasOverflow, RasUnderflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: each word encodes its own address.
    assign ImemData = ImemAddr + 32'h1000_0000;

    fetch_pc_unit #(
        .ADDR_W(32), .INSTR_W(32), .RAS_DEPTH(8), .RESET_PC(32'h0), .NOP(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .PcSource(PcSource),
        .SIG_Kill(SIG_Kill), .SIG_Stall(SIG_Stall),
        .SIG_Call(SIG_Call), .SIG_CallRs1(SIG_CallRs1),
        .JumpTarget(JumpTarget), .BranchTarget(BranchTarget), .Rs1Target(Rs1Target),
        .ImemAddr(ImemAddr), .ImemData(ImemData),
        .IfIdInstr(IfIdInstr), .IfIdPc(IfIdPc), .IfIdPcPlus4(IfIdPcPlus4),
        .IfIdValid(IfIdValid), .RasEmpty(RasEmpty),
        .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present control inputs, then advance one rising edge and settle.
    task automatic applyStimulus(input logic [2:0] src, input logic kill, input logic stall,
                                 input logic call, input logic callRs1);
        PcSource    = src;
        SIG_Kill    = kill;
        SIG_Stall   = stall;
        SIG_Call    = call;
        SIG_CallRs1 = callRs1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        JumpTarget = 32'h0; BranchTarget = 32'h0; Rs1Target = 32'h0;
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_pc",    ImemAddr, 32'h0);
        checkOutput("rst_valid", IfIdValid, 32'h0);
        checkOutput("rst_instr", IfIdInstr, 32'h0);
        checkOutput("rst_ifpc",  IfIdPc, 32'h0);
        checkOutput("rst_ifp4",  IfIdPcPlus4, 32'h0);
        checkOutput("rst_empty", RasEmpty, 32'h1);
        checkOutput("rst_ovf",   RasOverflow, 32'h0);
        checkOutput("rst_unf",   RasUnderflow, 32'h0);
        reset = 1'b0;

        // Free-running fetch
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("run1_pc",    ImemAddr, 32'h4);
        checkOutput("run1_ifpc",  IfIdPc, 32'h0);
        checkOutput("run1_valid", IfIdValid, 32'h1);
        checkOutput("run1_instr", IfIdInstr, 32'h1000_0000);
        checkOutput("run1_ifp4",  IfIdPcPlus4, 32'h4);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("run2_pc",   ImemAddr, 32'h8);
        checkOutput("run2_ifpc", IfIdPc, 32'h4);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("run3_pc",   ImemAddr, 32'hC);
        checkOutput("run3_ifpc", IfIdPc, 32'h8);

        // Jump with kill
        JumpTarget = 32'h100;
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("jmp_pc",     ImemAddr, 32'h100);
        checkOutput("jmp_valid",  IfIdValid, 32'h0);
        checkOutput("jmp_instr",  IfIdInstr, 32'h0);
        checkOutput("jmp_ifpc",   IfIdPc, 32'hC);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("jmp2_pc",    ImemAddr, 32'h104);
        checkOutput("jmp2_ifpc",  IfIdPc, 32'h100);
        checkOutput("jmp2_instr", IfIdInstr, 32'h1000_0100);
        checkOutput("jmp2_valid", IfIdValid, 32'h1);

        // Call at IfIdPc=0x20, then return
        JumpTarget = 32'h20;
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("call_ifpc", IfIdPc, 32'h20);
        JumpTarget = 32'h200;
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("call_pc",    ImemAddr, 32'h200);
        checkOutput("call_empty", RasEmpty, 32'h0);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ret_pc",    ImemAddr, 32'h24);
        checkOutput("ret_empty", RasEmpty, 32'h1);
        checkOutput("ret_unf",   RasUnderflow, 32'h0);

        // Nine pushes into an 8-deep stack: 0x28..0x48
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("push8_ovf", RasOverflow, 32'h0);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("push9_ovf", RasOverflow, 32'h1);
        checkOutput("push9_pc",  ImemAddr, 32'h4C);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("pop%0d_pc", i), ImemAddr, 32'h48 - 32'(4 * i));
        end
        checkOutput("pop8_empty", RasEmpty, 32'h1);
        checkOutput("pop8_unf",   RasUnderflow, 32'h0);
        applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pop9_unf",   RasUnderflow, 32'h1);
        checkOutput("pop9_stale", ImemAddr, 32'h48);
        checkOutput("pop9_empty", RasEmpty, 32'h1);

        // Three pushes, then a 3-cycle stall carrying a killed jump and a call
        for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_stall_pc", ImemAddr, 32'h54);
        JumpTarget = 32'h300;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("stall%0d_pc", i),    ImemAddr, 32'h54);
            checkOutput($sformatf("stall%0d_ifpc", i),  IfIdPc, 32'h50);
            checkOutput($sformatf("stall%0d_valid", i), IfIdValid, 32'h1);
            checkOutput($sformatf("stall%0d_instr", i), IfIdInstr, 32'h1000_0050);
        end
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("unstall_pc",    ImemAddr, 32'h300);
        checkOutput("unstall_valid", IfIdValid, 32'h0);
        checkOutput("unstall_ifpc",  IfIdPc, 32'h54);

        // Reset asserted during a stall with valid IF/ID and three RAS entries
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_valid", IfIdValid, 32'h1);
        checkOutput("hold_empty", RasEmpty, 32'h0);
        reset = 1'b1;
        applyStimulus(3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        checkOutput("rst2_pc",    ImemAddr, 32'h0);
        checkOutput("rst2_valid", IfIdValid, 32'h0);
        checkOutput("rst2_ifpc",  IfIdPc, 32'h0);
        checkOutput("rst2_empty", RasEmpty, 32'h1);
        checkOutput("rst2_ovf",   RasOverflow, 32'h0);
        checkOutput("rst2_unf",   RasUnderflow, 32'h0);

        // Branch, register call, PC+4 wrap, and return to the rs1 call site
        BranchTarget = 32'h400;
        applyStimulus(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("br_pc",    ImemAddr, 32'h400);
        checkOutput("br_ifp4",  IfIdPcPlus4, 32'h4);
        Rs1Target = 32'h500;
        applyStimulus(3'b011, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rs1_pc",    ImemAddr, 32'h500);
        checkOutput("rs1_empty", RasEmpty, 32'h0);
        JumpTarget = 32'hFFFF_FFFC;
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_pc",   ImemAddr, 32'h0);
        checkOutput("wrap_ifp4", IfIdPcPlus4, 32'h0);
        applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ret2_pc",    ImemAddr, 32'h4);
        checkOutput("ret2_empty", RasEmpty, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
